risc_multicycle_core: RTL and testbench
=======================================

RISC_MULTICYCLE_CORE -- requirements
Module: risc_multicycle_core

Interface
REQ-001 SHALL have parameter DW, default 8, meaning datapath and register width in bits (legal range 8..32).
REQ-002 SHALL have parameter AW, default 8, meaning instruction and data address width in bits.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 run  in  1  allows leaving FETCH when 1; holds the core in FETCH when 0.
REQ-006 swt_en  in  1  when 1, the fetched instruction is swt_inst, not imem_rdata.
REQ-007 swt_inst  in  16  switch-supplied instruction.
REQ-008 imem_addr  out  AW  instruction address, equal to PC.
REQ-009 imem_rdata  in  16  instruction word, combinational read of imem_addr.
REQ-010 dmem_addr  out  AW  data address, equal to the low AW bits of the ALU result.
REQ-011 dmem_wdata  out  DW  store data.
REQ-012 dmem_we, dmem_re  out  1 each  write and read strobes, held high until dmem_ready.
REQ-013 dmem_rdata  in  DW  load data, valid in the cycle where dmem_ready=1.
REQ-014 dmem_ready  in  1  completes the pending data access.
REQ-015 dout1  out  DW  registered ALU result.
REQ-016 dout2  out  DW  last register-file write data.
REQ-017 halted  out  1  high while in the HALT state.

Function
REQ-018 Instruction format SHALL be op[15:12], ra[11:8], rb[7:4], rc/imm[3:0]; imm is sign-extended to DW.
REQ-019 Opcode decode SHALL be:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed, result 0 or 1): rc <= ra op rb.
- 5 ADDI: rb <= ra+imm.
- 6 LW: rb <= mem[ra+imm].
- 7 SW: mem[ra+imm] <= rb.
- 8 BEQ: if ra==rb, PC <= PC+1+imm.
- F HALT.
- 9..E: NOP.
REQ-020 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-021 FETCH with run=1: latch IR from the selected source, PC <= PC+1, go to DECODE. FETCH with run=0: stay in FETCH with no state change.
REQ-022 DECODE SHALL latch operand registers A=R[ra] and B=R[rb].
REQ-023 EXEC SHALL latch the ALU result into dout1, then:
- ALU/ADDI: go to WB.
- LW/SW: go to MEM.
- BEQ/NOP: go to FETCH.
- HALT: go to HALT.
REQ-024 BEQ target SHALL be computed in EXEC from the incremented PC; all addition wraps modulo 2^AW for PC and 2^DW for data.
REQ-025 MEM SHALL assert exactly one strobe and stay in MEM until dmem_ready=1. On ready, LW goes to WB (latching dmem_rdata) and SW goes to FETCH.
REQ-026 dmem_ready asserted outside MEM SHALL be ignored.
REQ-027 WB SHALL write R[rc] for ALU ops and R[rb] for ADDI/LW, update dout2, then go to FETCH.
REQ-028 Latency in cycles SHALL be:
- ALU/ADDI: 4.
- LW: 5+waits.
- SW: 4+waits.
- BEQ/NOP: 3.
REQ-029 HALT SHALL be exited only by rst; run and swt_en are ignored in HALT.
REQ-030 The register file SHALL have 16 entries, all writable, with at most one write per cycle, in WB only.

Reset
REQ-031 rst=1 SHALL force: PC=0, state FETCH, all registers 0, IR=0, dout1=dout2=0, strobes=0, halted=0.
REQ-032 rst SHALL take priority over every other event, including mid-MEM; the pending access is abandoned and no write occurs.

Structure
REQ-033 Opcode constants and the state encoding SHALL live in a shared package risc_pkg.
REQ-034 The ALU SHALL be a sub-module risc_alu (combinational, DW-parametrised, with a zero flag).

Verification
REQ-035 ADDI R1,R0,5 then ADD R2,R1,R1 -> dout2=10 and R2=10, with the second instruction completing 4 cycles after the first.
REQ-036 SW R1 to addr 3 with dmem_ready delayed 3 cycles -> dmem_we high for 4 cycles, dmem_wdata=5, next FETCH at PC=3.
REQ-037 BEQ R1,R1,imm=-2 at PC=4 -> next imem_addr=3; with PC=255 and imm=+1 -> target wraps to 1.
REQ-038 SUB 0-1 with DW=8 -> dout1=0xFF; rerun with DW=16 -> dout1=0xFFFF; SLT(-1,1)=1.
REQ-039 HALT -> halted=1 persists with run toggling; rst mid-MEM for LW -> no register write, PC=0.
REQ-040 swt_en=1 with swt_inst=ADDI R3,R0,-1 -> R3=0xFF regardless of imem_rdata.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the multicycle RISC core.
//   - Opcode constants (instruction bits [15:12])
//   - FSM state encoding
//   - ALU operation selector
package risc_pkg;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpSlt  = 4'h4;
  localparam logic [3:0] OpAddi = 4'h5;
  localparam logic [3:0] OpLw   = 4'h6;
  localparam logic [3:0] OpSw   = 4'h7;
  localparam logic [3:0] OpBeq  = 4'h8;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_e;

  // Register-register ops write rc; everything else that writes uses rb.
  function automatic logic is_rtype(logic [3:0] op);
    return op <= OpSlt;
  endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU for the multicycle RISC core.
//   a_i, b_i : operands (DW bits)
//   op_i     : operation select
//   y_o      : result (DW bits), wraps modulo 2^DW
//   zero_o   : high when y_o is all zeros
module risc_alu
  import risc_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  alu_op_e       op_i,
  output logic [DW-1:0] y_o,
  output logic          zero_o
);

  always_comb begin
    y_o = a_i + b_i;
    unique case (op_i)
      AluAdd:  y_o = a_i + b_i;
      AluSub:  y_o = a_i - b_i;
      AluAnd:  y_o = a_i & b_i;
      AluOr:   y_o = a_i | b_i;
      AluSlt:  y_o = DW'($signed(a_i) < $signed(b_i));
      default: y_o = a_i + b_i;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/risc_multicycle_core.sv
// Multicycle 16-bit-instruction RISC core.
//   clk, rst           : clock, synchronous active-high reset
//   run                : permits leaving FETCH
//   swt_en, swt_inst   : optional switch-supplied instruction source
//   imem_addr/rdata    : instruction port (address = PC, combinational read)
//   dmem_*             : data port, strobes held until dmem_ready
//   dout1              : registered ALU result
//   dout2              : last register-file write data
//   halted             : high in HALT
module risc_multicycle_core
  import risc_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          swt_en,
  input  logic [15:0]   swt_inst,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          dmem_we,
  output logic          dmem_re,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ready,
  output logic [DW-1:0] dout1,
  output logic [DW-1:0] dout2,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] dout1_q, dout1_d;
  logic [DW-1:0] dout2_q, dout2_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic [DW-1:0] rf_q [16];

  logic          rf_we;
  logic [3:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  logic [3:0]    op, ra, rb, rc;
  logic [DW-1:0] imm_dw;
  logic [AW-1:0] imm_aw;

  alu_op_e       alu_op;
  logic [DW-1:0] alu_b, alu_y;
  logic          alu_zero;

  assign op     = ir_q[15:12];
  assign ra     = ir_q[11:8];
  assign rb     = ir_q[7:4];
  assign rc     = ir_q[3:0];
  assign imm_dw = DW'($signed(ir_q[3:0]));
  assign imm_aw = AW'($signed(ir_q[3:0]));

  // ALU operand/operation select; address ops add the immediate, BEQ uses the zero flag.
  always_comb begin
    alu_op = AluAdd;
    alu_b  = b_q;
    case (op)
      OpAdd:               alu_op = AluAdd;
      OpSub:               alu_op = AluSub;
      OpAnd:               alu_op = AluAnd;
      OpOr:                alu_op = AluOr;
      OpSlt:               alu_op = AluSlt;
      OpAddi, OpLw, OpSw:  alu_b  = imm_dw;
      OpBeq:               alu_op = AluSub;
      default:             alu_op = AluAdd;
    endcase
  end

  risc_alu #(
    .DW (DW)
  ) u_alu (
    .a_i    (a_q),
    .b_i    (alu_b),
    .op_i   (alu_op),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (run) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (op <= OpAddi) begin
          state_d = StWb;
        end else if (op == OpLw || op == OpSw) begin
          state_d = StMem;
        end else if (op == OpHalt) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (dmem_ready) state_d = (op == OpLw) ? StWb : StFetch;
      end
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  // FSM: outputs. Strobes drop immediately under reset so an abandoned access never completes.
  always_comb begin
    dmem_we = 1'b0;
    dmem_re = 1'b0;
    halted  = (state_q == StHalt);
    if (state_q == StMem && !rst) begin
      dmem_we = (op == OpSw);
      dmem_re = (op == OpLw);
    end
  end

  // Datapath next state
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    dout1_d  = dout1_q;
    dout2_d  = dout2_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = rb;
    rf_wdata = dout1_q;
    unique case (state_q)
      StFetch: begin
        if (run) begin
          ir_d = swt_en ? swt_inst : imem_rdata;
          pc_d = pc_q + AW'(1);
        end
      end
      StDecode: begin
        a_d = rf_q[ra];
        b_d = rf_q[rb];
      end
      StExec: begin
        dout1_d = alu_y;
        // pc_q already points past the branch here
        if (op == OpBeq && alu_zero) pc_d = pc_q + imm_aw;
      end
      StMem: begin
        if (dmem_ready && op == OpLw) mdr_d = dmem_rdata;
      end
      StWb: begin
        rf_we    = 1'b1;
        rf_waddr = is_rtype(op) ? rc : rb;
        rf_wdata = (op == OpLw) ? mdr_q : dout1_q;
        dout2_d  = rf_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
      mdr_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
      mdr_q   <= mdr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = AW'(dout1_q);
  assign dmem_wdata = b_q;
  assign dout1      = dout1_q;
  assign dout2      = dout2_q;

endmodule

// File: tb/tb_risc_multicycle_core.sv
// Self-checking bench for risc_multicycle_core: directed scenarios plus a random
// instruction stream, checked against an instruction-level reference model.
module tb_risc_multicycle_core;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, run, swt_en, dmem_ready;
  logic [15:0]   swt_inst, imem_rdata;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata, dout1, dout2;
  logic          dmem_we, dmem_re, halted;

  // second instance at DW=16, driven only through the switch port
  logic          run16, swt_en16;
  logic [15:0]   swt16;
  logic [7:0]    iaddr16, daddr16;
  logic [15:0]   wdata16, d1_16, d2_16;
  logic          we16, re16, h16;

  logic [15:0]   imem [256];
  logic [DW-1:0] env_mem [256];

  assign imem_rdata = imem[imem_addr];

  always #5 clk = ~clk;

  risc_multicycle_core #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .run(run), .swt_en(swt_en), .swt_inst(swt_inst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dout1(dout1), .dout2(dout2), .halted(halted)
  );

  risc_multicycle_core #(.DW(16), .AW(8)) dut16 (
    .clk(clk), .rst(rst), .run(run16), .swt_en(swt_en16), .swt_inst(swt16),
    .imem_addr(iaddr16), .imem_rdata(16'h9000),
    .dmem_addr(daddr16), .dmem_wdata(wdata16), .dmem_we(we16), .dmem_re(re16),
    .dmem_rdata(16'h0000), .dmem_ready(1'b0),
    .dout1(d1_16), .dout2(d2_16), .halted(h16)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_r [16];
  int m_mem [256];
  int m_pc, m_dout1, m_dout2, m_addr;
  bit m_d1_valid, m_is_wb, m_is_mem, m_is_sw;

  // data-port responder state
  int scnt, wait_n, cap_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sv(input int v);
    return (v >= (1 << (DW - 1))) ? v - (1 << DW) : v;
  endfunction

  // Executes one instruction at ISA level; returns its expected cycle count.
  function automatic int model_step(input logic [15:0] inst, input int waits);
    int op, ra, rb, rc, imm, va, vb, res, lat;
    int dmask, amask;
    dmask = (1 << DW) - 1;
    amask = (1 << AW) - 1;
    op  = int'(inst[15:12]);
    ra  = int'(inst[11:8]);
    rb  = int'(inst[7:4]);
    rc  = int'(inst[3:0]);
    imm = inst[3] ? int'(inst[3:0]) - 16 : int'(inst[3:0]);
    va  = m_r[ra];
    vb  = m_r[rb];
    m_pc = (m_pc + 1) & amask;
    m_d1_valid = 1'b1;
    m_is_wb = 1'b0;
    m_is_mem = 1'b0;
    m_is_sw = 1'b0;
    lat = 3;
    res = 0;
    case (op)
      0: res = (va + vb) & dmask;
      1: res = (va - vb) & dmask;
      2: res = va & vb;
      3: res = va | vb;
      4: res = (sv(va) < sv(vb)) ? 1 : 0;
      5, 6, 7: res = (va + imm) & dmask;
      default: m_d1_valid = 1'b0;
    endcase
    if (m_d1_valid) m_dout1 = res;
    case (op)
      0, 1, 2, 3, 4: begin
        m_r[rc] = res; m_dout2 = res; m_is_wb = 1'b1; lat = 4;
      end
      5: begin
        m_r[rb] = res; m_dout2 = res; m_is_wb = 1'b1; lat = 4;
      end
      6: begin
        m_addr = res & amask;
        m_r[rb] = m_mem[m_addr]; m_dout2 = m_mem[m_addr];
        m_is_wb = 1'b1; m_is_mem = 1'b1; lat = 5 + waits;
      end
      7: begin
        m_addr = res & amask;
        m_mem[m_addr] = vb;
        m_is_mem = 1'b1; m_is_sw = 1'b1; lat = 4 + waits;
      end
      8: if (va == vb) m_pc = (m_pc + imm) & amask;
      default: ;
    endcase
    return lat;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    m_pc = 0;
    m_dout1 = 0;
    m_dout2 = 0;
  endtask

  // One clock: answer pending data accesses, then advance past the edge.
  task automatic cyc();
    if (dmem_we === 1'b1 || dmem_re === 1'b1) begin
      scnt++;
      cap_addr = int'(dmem_addr);
      if (scnt > wait_n) begin
        dmem_ready = 1'b1;
        if (dmem_re) dmem_rdata = env_mem[dmem_addr];
        if (dmem_we) env_mem[dmem_addr] = dmem_wdata;
      end
    end
    @(posedge clk);
    #1;
    dmem_ready = 1'b0;
    run = 1'b0;
    swt_en = 1'b0;
  endtask

  task automatic exec(input logic [15:0] inst, input int waits, input bit use_swt);
    int old_pc, old_d2, lat;
    old_pc = m_pc;
    old_d2 = m_dout2;
    lat = model_step(inst, waits);
    if (use_swt) begin
      imem[old_pc] = 16'hF000;
      swt_inst = inst;
      swt_en = 1'b1;
    end else begin
      imem[old_pc] = inst;
      swt_inst = 16'($urandom);
      swt_en = 1'b0;
    end
    wait_n = waits;
    scnt = 0;
    run = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      cyc();
      if (c == 2) chk("pc_inc", 32'(imem_addr), 32'((old_pc + 1) % (1 << AW)));
      if (c == lat - 1 && m_is_wb && m_dout2 != old_d2)
        chk("wb_not_early", 32'(dout2), 32'(old_d2));
    end
    chk("pc", 32'(imem_addr), 32'(m_pc));
    chk("dout2", 32'(dout2), 32'(m_dout2));
    chk("halted", 32'(halted), 32'(inst[15:12] == 4'hF));
    if (m_d1_valid) chk("dout1", 32'(dout1), 32'(m_dout1));
    if (m_is_mem) begin
      chk("strobe_cycles", 32'(scnt), 32'(waits + 1));
      chk("dmem_addr", 32'(cap_addr), 32'(m_addr));
    end
    if (m_is_sw) chk("store_data", 32'(env_mem[m_addr]), 32'(m_mem[m_addr]));
  endtask

  initial begin
    logic [15:0] inst;
    logic [3:0]  rop;
    int hold_pc;

    rst = 1'b1; run = 1'b0; swt_en = 1'b0; swt_inst = 16'h0; dmem_ready = 1'b0;
    dmem_rdata = '0; run16 = 1'b0; swt_en16 = 1'b0; swt16 = 16'h0;
    scnt = 0; wait_n = 0; cap_addr = 0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h9000;
      env_mem[i] = DW'($urandom);
      m_mem[i] = int'(env_mem[i]);
    end
    model_reset();

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pc", 32'(imem_addr), 32'h0);
    chk("rst_dout1", 32'(dout1), 32'h0);
    chk("rst_dout2", 32'(dout2), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_re", 32'(dmem_re), 32'h0);
    rst = 1'b0;

    // ADDI R1,R0,5 ; ADD R2,R1,R1
    exec(16'h5015, 0, 1'b0);
    exec(16'h0112, 0, 1'b0);
    chk("add_r2", 32'(dout2), 32'd10);
    // SW R1 -> mem[3], three wait cycles
    exec(16'h7013, 3, 1'b0);
    chk("sw_mem3", 32'(env_mem[3]), 32'd5);
    chk("sw_next_pc", 32'(imem_addr), 32'd3);
    // ADDI R4,R2,0 exposes R2
    exec(16'h5240, 0, 1'b0);
    chk("r2_value", 32'(dout2), 32'd10);
    // BEQ R1,R1,-2 at PC 4
    exec(16'h811E, 0, 1'b0);
    chk("beq_back", 32'(imem_addr), 32'd3);
    // switch-supplied ADDI R3,R0,-1 while imem holds HALT
    exec(16'h503F, 0, 1'b1);
    chk("swt_r3", 32'(dout2), 32'hFF);
    // SUB 0-1 and SLT(-1,1)
    exec(16'h5051, 0, 1'b0);
    exec(16'h1056, 0, 1'b0);
    chk("sub_wrap8", 32'(dout1), 32'hFF);
    exec(16'h4357, 0, 1'b0);
    chk("slt_neg", 32'(dout1), 32'h1);
    // LW R8 <- mem[3] with two waits
    exec(16'h6083, 2, 1'b0);
    chk("lw_r8", 32'(dout2), 32'd5);

    // DW=16 instance: ADDI R1,R0,1 ; SUB R2,R0,R1
    swt_en16 = 1'b1; run16 = 1'b1; swt16 = 16'h5011;
    repeat (4) cyc();
    swt16 = 16'h1012;
    repeat (4) cyc();
    run16 = 1'b0;
    chk("sub_wrap16_d1", 32'(d1_16), 32'hFFFF);
    chk("sub_wrap16_d2", 32'(d2_16), 32'hFFFF);

    // random instruction stream (no HALT)
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 14));
      inst = {rop, 12'($urandom)};
      exec(inst, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // walk to PC 255, then BEQ R0,R0,+1 wraps to 1
    for (int n = 0; n < 256 && m_pc != 255; n++) exec(16'h9000, 0, 1'b0);
    chk("at_pc255", 32'(imem_addr), 32'd255);
    exec(16'h8001, 0, 1'b0);
    chk("beq_wrap", 32'(imem_addr), 32'd1);

    // HALT persists regardless of run/swt_en
    exec(16'hF000, 0, 1'b0);
    hold_pc = int'(imem_addr);
    for (int n = 0; n < 10; n++) begin
      run = 1'($urandom_range(0, 1));
      swt_en = 1'($urandom_range(0, 1));
      swt_inst = 16'h5011;
      @(posedge clk); #1;
      chk("halt_hold", 32'(halted), 32'h1);
      chk("halt_pc", 32'(imem_addr), 32'(hold_pc));
    end
    run = 1'b0; swt_en = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("halt_exit", 32'(halted), 32'h0);
    chk("halt_exit_pc", 32'(imem_addr), 32'h0);
    model_reset();

    // LW R9 <- mem[2], reset while the access is pending
    env_mem[2] = 8'hA5;
    m_mem[2] = 32'hA5;
    imem[0] = 16'h6092;
    wait_n = 1000;
    scnt = 0;
    run = 1'b1;
    repeat (3) cyc();
    chk("lw_pending", 32'(dmem_re), 32'h1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midmem_pc", 32'(imem_addr), 32'h0);
    chk("midmem_re", 32'(dmem_re), 32'h0);
    chk("midmem_dout2", 32'(dout2), 32'h0);
    chk("midmem_halted", 32'(halted), 32'h0);
    repeat (3) cyc();
    chk("midmem_idle", 32'(dout2), 32'h0);
    // ADDI R10,R9,0 exposes R9
    exec(16'h59A0, 0, 1'b0);
    chk("midmem_r9", 32'(dout2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
